// File: rtl/riscv_lsu_unit.sv
// RISC-V load/store unit: decodes one access per handshake, drives a req/gnt/rvalid
// memory port with timeout, and returns extended load data or a precise exception.
module riscv_lsu_unit #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic              ex_is_store_i,
   input  logic [2:0]        ex_funct3_i,
   input  logic [ADDR_W-1:0] ex_addr_i,
   input  logic [XLEN-1:0]   ex_wdata_i,
   input  logic [4:0]        ex_rd_i,
   output logic              mem_req_o,
   input  logic              mem_gnt_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic              mem_rvalid_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   input  logic              mem_err_i,
   output logic              wb_valid_o,
   output logic              wb_we_o,
   output logic [4:0]        wb_rd_o,
   output logic [XLEN-1:0]   wb_data_o,
   output logic              exc_valid_o,
   output logic [3:0]        exc_cause_o,
   output logic [ADDR_W-1:0] exc_tval_o
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, EXC} state_t;
   state_t state, state_next;

   logic              store_q, uns_q;
   logic [1:0]        sz_q;
   logic [ADDR_W-1:0] addr_q;
   logic [4:0]        rd_q;
   logic [31:0]       cnt_q;

   logic              dec_legal, dec_uns, dec_misal;
   logic [1:0]        dec_sz;
   logic [NB-1:0]     size_mask, be_calc;
   logic [XLEN-1:0]   wdata_calc, shifted, ld_mask, ld_calc;
   logic              sign_bit;
   logic              timeout_hit;

   // Size decode: dec_sz is log2(bytes); 64-bit-only encodings are illegal at XLEN=32.
   always_comb begin
      dec_legal = 1'b1;
      dec_sz    = 2'd0;
      dec_uns   = 1'b0;
      if (ex_is_store_i) begin
         case (ex_funct3_i)
            3'b000:  dec_sz = 2'd0;
            3'b001:  dec_sz = 2'd1;
            3'b010:  dec_sz = 2'd2;
            3'b011:  begin dec_sz = 2'd3; dec_legal = (XLEN == 64); end
            default: dec_legal = 1'b0;
         endcase
      end else begin
         case (ex_funct3_i)
            3'b000:  dec_sz = 2'd0;
            3'b001:  dec_sz = 2'd1;
            3'b010:  dec_sz = 2'd2;
            3'b100:  begin dec_sz = 2'd0; dec_uns = 1'b1; end
            3'b101:  begin dec_sz = 2'd1; dec_uns = 1'b1; end
            3'b011:  begin dec_sz = 2'd3; dec_legal = (XLEN == 64); end
            3'b110:  begin dec_sz = 2'd2; dec_uns = 1'b1; dec_legal = (XLEN == 64); end
            default: dec_legal = 1'b0;
         endcase
      end
      case (dec_sz)
         2'd0:    dec_misal = 1'b0;
         2'd1:    dec_misal = ex_addr_i[0];
         2'd2:    dec_misal = |ex_addr_i[1:0];
         default: dec_misal = |ex_addr_i[2:0];
      endcase
   end

   always_comb begin
      case (dec_sz)
         2'd0:    size_mask = NB'(1);
         2'd1:    size_mask = NB'(3);
         2'd2:    size_mask = NB'(15);
         default: size_mask = NB'(8'hFF);
      endcase
      be_calc = size_mask << ex_addr_i[OFF_W-1:0];
      case (dec_sz)
         2'd0:    wdata_calc = {NB{ex_wdata_i[7:0]}};
         2'd1:    wdata_calc = {(NB/2){ex_wdata_i[15:0]}};
         2'd2:    wdata_calc = {(NB/4){ex_wdata_i[31:0]}};
         default: wdata_calc = ex_wdata_i;
      endcase
   end

   // Load extension: lanes above the access size are replaced by zero or sign fill.
   always_comb begin
      shifted = mem_rdata_i >> {addr_q[OFF_W-1:0], 3'b000};
      case (sz_q)
         2'd0:    begin ld_mask = XLEN'(64'hFF);        sign_bit = shifted[7];      end
         2'd1:    begin ld_mask = XLEN'(64'hFFFF);      sign_bit = shifted[15];     end
         2'd2:    begin ld_mask = XLEN'(64'hFFFF_FFFF); sign_bit = shifted[31];     end
         default: begin ld_mask = '1;                   sign_bit = shifted[XLEN-1]; end
      endcase
      ld_calc = (sign_bit && !uns_q) ? (shifted | ~ld_mask) : (shifted & ld_mask);
   end

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (ex_valid_i) state_next = (!dec_legal || dec_misal) ? EXC : REQ;
         REQ:  if (mem_gnt_i) state_next = WAIT;
         WAIT: begin
            if (mem_rvalid_i)     state_next = mem_err_i ? EXC : DONE;
            else if (timeout_hit) state_next = EXC;
         end
         DONE:    state_next = IDLE;
         EXC:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ex_ready_o  = (state == IDLE);
      mem_req_o   = (state == REQ);
      wb_valid_o  = (state == DONE);
      wb_we_o     = (state == DONE) && !store_q;
      exc_valid_o = (state == EXC);
      wb_rd_o     = rd_q;
   end

   // Capture, memory-port registers, counter and the held wb/exception results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_q     <= 1'b0;
         uns_q       <= 1'b0;
         sz_q        <= 2'd0;
         addr_q      <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= '0;
         mem_wdata_o <= '0;
         wb_data_o   <= '0;
         exc_cause_o <= '0;
         exc_tval_o  <= '0;
      end else begin
         case (state)
            IDLE: if (ex_valid_i) begin
               store_q <= ex_is_store_i;
               uns_q   <= dec_uns;
               sz_q    <= dec_sz;
               addr_q  <= ex_addr_i;
               rd_q    <= ex_rd_i;
               if (!dec_legal) begin
                  exc_cause_o <= 4'd2;
                  exc_tval_o  <= ex_addr_i;
               end else if (dec_misal) begin
                  exc_cause_o <= ex_is_store_i ? 4'd6 : 4'd4;
                  exc_tval_o  <= ex_addr_i;
               end else begin
                  mem_we_o    <= ex_is_store_i;
                  mem_addr_o  <= {ex_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  mem_be_o    <= be_calc;
                  mem_wdata_o <= wdata_calc;
               end
            end
            REQ: if (mem_gnt_i) cnt_q <= '0;
            WAIT: begin
               if (mem_rvalid_i) begin
                  if (mem_err_i) begin
                     exc_cause_o <= store_q ? 4'd7 : 4'd5;
                     exc_tval_o  <= addr_q;
                  end else if (!store_q) begin
                     wb_data_o <= ld_calc;
                  end
               end else begin
                  cnt_q <= cnt_q + 32'd1;
                  if (timeout_hit) begin
                     exc_cause_o <= store_q ? 4'd7 : 4'd5;
                     exc_tval_o  <= addr_q;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_riscv_lsu_unit.sv
// Directed self-checking bench for riscv_lsu_unit: a 32-bit instance with TIMEOUT=4
// and a 64-bit instance, driven one at a time through shared stimulus signals.
module tb_riscv_lsu_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel64 = 1'b0;
   logic        ex_valid = 1'b0, ex_is_store = 1'b0;
   logic [2:0]  ex_funct3 = '0;
   logic [63:0] ex_addr = '0, ex_wdata = '0, mem_rdata = '0;
   logic [4:0]  ex_rd = '0;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;

   int n_compared = 0;
   int n_mismatch = 0;

   always #5 clk = ~clk;

   logic        ready32, req32, we32, wbv32, wbwe32, excv32;
   logic [31:0] addr32, wdata32, wbd32, tval32;
   logic [3:0]  be32, cause32;
   logic [4:0]  wbrd32;
   logic        ready64, req64, we64, wbv64, wbwe64, excv64;
   logic [31:0] addr64, tval64;
   logic [63:0] wdata64, wbd64;
   logic [7:0]  be64;
   logic [3:0]  cause64;
   logic [4:0]  wbrd64;

   riscv_lsu_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid && !sel64), .ex_ready_o(ready32),
      .ex_is_store_i(ex_is_store), .ex_funct3_i(ex_funct3), .ex_addr_i(ex_addr[31:0]),
      .ex_wdata_i(ex_wdata[31:0]), .ex_rd_i(ex_rd), .mem_req_o(req32), .mem_gnt_i(mem_gnt),
      .mem_we_o(we32), .mem_addr_o(addr32), .mem_be_o(be32), .mem_wdata_o(wdata32),
      .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata[31:0]), .mem_err_i(mem_err),
      .wb_valid_o(wbv32), .wb_we_o(wbwe32), .wb_rd_o(wbrd32), .wb_data_o(wbd32),
      .exc_valid_o(excv32), .exc_cause_o(cause32), .exc_tval_o(tval32));

   riscv_lsu_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) dut64 (
      .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid && sel64), .ex_ready_o(ready64),
      .ex_is_store_i(ex_is_store), .ex_funct3_i(ex_funct3), .ex_addr_i(ex_addr[31:0]),
      .ex_wdata_i(ex_wdata), .ex_rd_i(ex_rd), .mem_req_o(req64), .mem_gnt_i(mem_gnt),
      .mem_we_o(we64), .mem_addr_o(addr64), .mem_be_o(be64), .mem_wdata_o(wdata64),
      .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
      .wb_valid_o(wbv64), .wb_we_o(wbwe64), .wb_rd_o(wbrd64), .wb_data_o(wbd64),
      .exc_valid_o(excv64), .exc_cause_o(cause64), .exc_tval_o(tval64));

   logic        o_ready, o_req, o_we, o_wbv, o_wbwe, o_excv;
   logic [63:0] o_addr, o_be, o_wdata, o_wbd, o_cause, o_tval, o_wbrd;
   assign o_ready = sel64 ? ready64 : ready32;
   assign o_req   = sel64 ? req64   : req32;
   assign o_we    = sel64 ? we64    : we32;
   assign o_wbv   = sel64 ? wbv64   : wbv32;
   assign o_wbwe  = sel64 ? wbwe64  : wbwe32;
   assign o_excv  = sel64 ? excv64  : excv32;
   assign o_addr  = sel64 ? {32'd0, addr64} : {32'd0, addr32};
   assign o_be    = sel64 ? {56'd0, be64}   : {60'd0, be32};
   assign o_wdata = sel64 ? wdata64         : {32'd0, wdata32};
   assign o_wbd   = sel64 ? wbd64           : {32'd0, wbd32};
   assign o_cause = sel64 ? {60'd0, cause64} : {60'd0, cause32};
   assign o_tval  = sel64 ? {32'd0, tval64} : {32'd0, tval32};
   assign o_wbrd  = sel64 ? {59'd0, wbrd64} : {59'd0, wbrd32};

   // Results of the most recent transaction, filled in by run_txn.
   logic        req_seen, stable, wb_seen, exc_seen, cap_we, cap_wbwe;
   logic [63:0] cap_addr, cap_be, cap_wdata, cap_wbd, cap_wbrd, cap_cause, cap_tval;
   int          wb_cyc, exc_cyc, ready_cyc;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatch++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access: grant after gnt_delay request cycles, optional response one cycle after grant,
   // optional stray error responses while still in REQ. Bounded at 40 cycles.
   task automatic run_txn(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [63:0] rdata, input logic err,
                          input int gnt_delay, input logic give_rvalid, input logic stray,
                          input logic [4:0] rd);
      int  req_cnt = 0;
      logic in_wait = 1'b0, rv_done = 1'b0;
      req_seen = 0; stable = 1; wb_seen = 0; exc_seen = 0; cap_we = 0; cap_wbwe = 0;
      cap_addr = '0; cap_be = '0; cap_wdata = '0; cap_wbd = '0; cap_wbrd = '0;
      cap_cause = '0; cap_tval = '0; wb_cyc = -1; exc_cyc = -1; ready_cyc = -1;
      ex_valid = 1; ex_is_store = st; ex_funct3 = f3; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
      tick();
      ex_valid = 0;
      for (int c = 1; c <= 40; c++) begin
         mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
         if (o_req) begin
            req_cnt++;
            if (!req_seen) begin
               req_seen = 1; cap_addr = o_addr; cap_be = o_be; cap_wdata = o_wdata; cap_we = o_we;
            end else if (o_addr !== cap_addr || o_be !== cap_be || o_wdata !== cap_wdata || o_we !== cap_we) begin
               stable = 0;
            end
            if (req_cnt > gnt_delay) begin
               mem_gnt = 1; in_wait = 1;
            end else if (stray) begin
               mem_rvalid = 1; mem_err = 1;
            end
         end else if (in_wait && give_rvalid && !rv_done) begin
            mem_rvalid = 1; mem_err = err; mem_rdata = rdata; rv_done = 1;
         end
         if (o_wbv && !wb_seen) begin
            wb_seen = 1; wb_cyc = c; cap_wbd = o_wbd; cap_wbwe = o_wbwe; cap_wbrd = o_wbrd;
         end
         if (o_excv && !exc_seen) begin
            exc_seen = 1; exc_cyc = c; cap_cause = o_cause; cap_tval = o_tval;
         end
         if ((wb_seen || exc_seen) && o_ready) begin
            ready_cyc = c;
            break;
         end
         tick();
      end
      mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
   endtask

   initial begin
      logic pulse_seen;
      $display("[TB] start");
      #23;
      check_output("rst_ready", {63'd0, o_ready}, 64'd1);
      check_output("rst_req", {63'd0, o_req}, 64'd0);
      check_output("rst_wbv", {63'd0, o_wbv}, 64'd0);
      check_output("rst_excv", {63'd0, o_excv}, 64'd0);
      check_output("rst_be", o_be, 64'd0);
      rst_n = 1;
      tick();

      // XLEN=32: LW 0x100, same-cycle grant, response next cycle
      run_txn(0, 3'b010, 64'h100, 64'h0, 64'hDEADBEEF, 0, 0, 1, 0, 5'd7);
      check_output("lw_be", cap_be, 64'hF);
      check_output("lw_addr", cap_addr, 64'h100);
      check_output("lw_we", {63'd0, cap_we}, 64'd0);
      check_output("lw_wb_cyc", 64'(wb_cyc), 64'd3);
      check_output("lw_wbd", cap_wbd, 64'hDEADBEEF);
      check_output("lw_wbwe", {63'd0, cap_wbwe}, 64'd1);
      check_output("lw_wbrd", cap_wbrd, 64'd7);
      check_output("lw_ready_cyc", 64'(ready_cyc), 64'd4);
      check_output("lw_wbd_hold", o_wbd, 64'hDEADBEEF);

      run_txn(0, 3'b000, 64'h103, 64'h0, 64'h80123456, 0, 0, 1, 0, 5'd1);
      check_output("lb_addr", cap_addr, 64'h100);
      check_output("lb_be", cap_be, 64'h8);
      check_output("lb_wbd", cap_wbd, 64'hFFFFFF80);
      run_txn(0, 3'b100, 64'h103, 64'h0, 64'h80123456, 0, 0, 1, 0, 5'd2);
      check_output("lbu_wbd", cap_wbd, 64'h00000080);
      run_txn(0, 3'b101, 64'h102, 64'h0, 64'hBEEF1234, 0, 1, 1, 0, 5'd3);
      check_output("lhu_be", cap_be, 64'hC);
      check_output("lhu_wbd", cap_wbd, 64'h0000BEEF);
      run_txn(0, 3'b001, 64'h102, 64'h0, 64'hBEEF1234, 0, 0, 1, 0, 5'd3);
      check_output("lh_wbd", cap_wbd, 64'hFFFFBEEF);

      // SH with grant delayed 3 cycles and stray error responses during REQ
      run_txn(1, 3'b001, 64'h202, 64'h1234ABCD, 64'h0, 0, 3, 1, 1, 5'd9);
      check_output("sh_be", cap_be, 64'hC);
      check_output("sh_wdata", cap_wdata, 64'hABCDABCD);
      check_output("sh_we", {63'd0, cap_we}, 64'd1);
      check_output("sh_stable", {63'd0, stable}, 64'd1);
      check_output("sh_wb_cyc", 64'(wb_cyc), 64'd6);
      check_output("sh_wbwe", {63'd0, cap_wbwe}, 64'd0);
      check_output("sh_exc", {63'd0, exc_seen}, 64'd0);
      check_output("sh_wbd_hold", cap_wbd, 64'hFFFFBEEF);
      run_txn(1, 3'b000, 64'h201, 64'h0000005A, 64'h0, 0, 0, 1, 0, 5'd0);
      check_output("sb_be", cap_be, 64'h2);
      check_output("sb_wdata", cap_wdata, 64'h5A5A5A5A);

      // Decode faults
      run_txn(0, 3'b010, 64'h102, 64'h0, 64'h0, 0, 0, 1, 0, 5'd4);
      check_output("lwmis_cyc", 64'(exc_cyc), 64'd1);
      check_output("lwmis_cause", cap_cause, 64'd4);
      check_output("lwmis_tval", cap_tval, 64'h102);
      check_output("lwmis_req", {63'd0, req_seen}, 64'd0);
      check_output("lwmis_wb", {63'd0, wb_seen}, 64'd0);
      run_txn(1, 3'b010, 64'h205, 64'h0, 64'h0, 0, 0, 1, 0, 5'd4);
      check_output("swmis_cause", cap_cause, 64'd6);
      run_txn(0, 3'b011, 64'h108, 64'h0, 64'h0, 0, 0, 1, 0, 5'd4);
      check_output("ld32_cause", cap_cause, 64'd2);
      check_output("ld32_tval", cap_tval, 64'h108);
      check_output("ld32_req", {63'd0, req_seen}, 64'd0);
      run_txn(0, 3'b110, 64'h108, 64'h0, 64'h0, 0, 0, 1, 0, 5'd4);
      check_output("lwu32_cause", cap_cause, 64'd2);
      run_txn(1, 3'b111, 64'h10C, 64'h0, 64'h0, 0, 0, 1, 0, 5'd4);
      check_output("st111_cause", cap_cause, 64'd2);

      // Bus error and timeout
      run_txn(0, 3'b010, 64'h104, 64'h0, 64'h11111111, 1, 0, 1, 0, 5'd5);
      check_output("lerr_cyc", 64'(exc_cyc), 64'd3);
      check_output("lerr_cause", cap_cause, 64'd5);
      check_output("lerr_tval", cap_tval, 64'h104);
      check_output("lerr_wb", {63'd0, wb_seen}, 64'd0);
      check_output("lerr_wbd_hold", o_wbd, 64'hFFFFBEEF);
      run_txn(1, 3'b010, 64'h300, 64'h0, 64'h0, 0, 0, 0, 0, 5'd5);
      check_output("tmo_cyc", 64'(exc_cyc), 64'd6);
      check_output("tmo_cause", cap_cause, 64'd7);
      check_output("tmo_tval", cap_tval, 64'h300);

      // Reset while in WAIT
      ex_valid = 1; ex_is_store = 0; ex_funct3 = 3'b010; ex_addr = 64'h400;
      tick();
      ex_valid = 0; mem_gnt = 1;
      tick();
      mem_gnt = 0;
      rst_n = 0;
      #1;
      check_output("rstw_ready", {63'd0, o_ready}, 64'd1);
      tick();
      rst_n = 1;
      pulse_seen = 0;
      mem_rvalid = 1; mem_rdata = 64'h12345678;
      for (int i = 0; i < 4; i++) begin
         tick();
         mem_rvalid = 0;
         if (o_wbv || o_excv || !o_ready) pulse_seen = 1;
      end
      check_output("rstw_quiet", {63'd0, pulse_seen}, 64'd0);
      check_output("rstw_wbd", o_wbd, 64'd0);

      // XLEN=64 instance
      sel64 = 1;
      run_txn(0, 3'b110, 64'h1004, 64'h0, 64'h80000001_12345678, 0, 0, 1, 0, 5'd10);
      check_output("lwu64_be", cap_be, 64'hF0);
      check_output("lwu64_addr", cap_addr, 64'h1000);
      check_output("lwu64_wbd", cap_wbd, 64'h00000000_80000001);
      run_txn(0, 3'b010, 64'h1004, 64'h0, 64'h80000001_12345678, 0, 0, 1, 0, 5'd11);
      check_output("lw64_wbd", cap_wbd, 64'hFFFFFFFF_80000001);
      run_txn(1, 3'b011, 64'h1008, 64'h11223344_55667788, 64'h0, 0, 0, 1, 0, 5'd12);
      check_output("sd64_be", cap_be, 64'hFF);
      check_output("sd64_addr", cap_addr, 64'h1008);
      check_output("sd64_wdata", cap_wdata, 64'h11223344_55667788);
      run_txn(1, 3'b010, 64'h1004, 64'h00000000_CAFEBABE, 64'h0, 0, 0, 1, 0, 5'd12);
      check_output("sw64_be", cap_be, 64'hF0);
      check_output("sw64_wdata", cap_wdata, 64'hCAFEBABE_CAFEBABE);
      run_txn(0, 3'b011, 64'h1010, 64'h0, 64'hFEDCBA98_76543210, 0, 0, 1, 0, 5'd13);
      check_output("ld64_wbd", cap_wbd, 64'hFEDCBA98_76543210);
      check_output("ld64_wbrd", cap_wbrd, 64'd13);
      run_txn(0, 3'b011, 64'h1004, 64'h0, 64'h0, 0, 0, 1, 0, 5'd13);
      check_output("ld64mis_cause", cap_cause, 64'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end
endmodule

// File: doc/riscv_lsu_unit.md
Name: riscv_lsu_unit

Overview:
Parametrised load/store unit between the execute stage and the data-memory port. It accepts one load or store per handshake and generates byte enables, lane-replicated write data and an XLEN-aligned address. It runs a request/grant/response FSM with a timeout, then returns sign/zero-extended load data or a store completion to writeback. Misaligned, illegal, bus-error and timed-out accesses raise a precise exception instead.

Parameters:
XLEN, 32, data width; 32 or 64 only; 64 enables LD/SD/LWU.
ADDR_W, 32, byte-address width.
TIMEOUT, 255, max cycles in WAIT before access fault; 0 disables timeout.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_valid_i  in  1  request valid from execute
ex_ready_o  out  1  LSU idle, can accept
ex_is_store_i  in  1  1=store, 0=load
ex_funct3_i  in  3  RISC-V load/store funct3
ex_addr_i  in  ADDR_W  effective byte address
ex_wdata_i  in  XLEN  store data (rs2)
ex_rd_i  in  5  load destination register
mem_req_o  out  1  memory request
mem_gnt_i  in  1  request accepted
mem_we_o  out  1  write enable
mem_addr_o  out  ADDR_W  address aligned to XLEN/8
mem_be_o  out  XLEN/8  byte enables
mem_wdata_o  out  XLEN  lane-aligned write data
mem_rvalid_i  in  1  response valid (loads and stores)
mem_rdata_i  in  XLEN  read data
mem_err_i  in  1  bus error, qualified by mem_rvalid_i
wb_valid_o  out  1  one-cycle completion pulse
wb_we_o  out  1  1 = write wb_data_o to wb_rd_o (loads only)
wb_rd_o  out  5  destination register
wb_data_o  out  XLEN  extended load data
exc_valid_o  out  1  one-cycle exception pulse
exc_cause_o  out  4  2 illegal, 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault
exc_tval_o  out  ADDR_W  faulting byte address

Behaviour:
- Clock and reset: one clock `clk`, asynchronous active-low reset `rst_n`.
- Reset: FSM to IDLE. All outputs 0 except ex_ready_o=1. Timeout counter is 0.
- Reset mid-operation: state is abandoned and no wb/exc pulse is produced.
- States: IDLE, REQ, WAIT, DONE, EXC.
- IDLE: ex_ready_o=1. On ex_valid_i, capture all ex_* inputs and decode size.
  - Loads: 000 B, 001 H, 010 W, 100 BU, 101 HU, 011 D (XLEN=64), 110 WU (XLEN=64).
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD (XLEN=64).
  - Any other funct3 -> EXC with cause 2.
  - Address not multiple of size -> EXC with cause 4 or 6.
  - Otherwise -> REQ.
- REQ: mem_req_o=1. mem_addr_o, mem_be_o, mem_wdata_o and mem_we_o are registered and held stable until mem_gnt_i. Same-cycle grant is allowed. On grant -> WAIT and clear the counter.
- WAIT: mem_rvalid_i is ignored before the grant cycle.
  - On mem_rvalid_i with mem_err_i=1 -> EXC, cause 5 or 7.
  - On mem_rvalid_i with mem_err_i=0 -> DONE.
  - Otherwise increment the counter. If TIMEOUT!=0 and counter==TIMEOUT-1 without rvalid -> EXC, cause 5 or 7.
- DONE: wb_valid_o=1 for one cycle, wb_we_o=~store, wb_rd_o=captured rd. Next state IDLE.
- EXC: exc_valid_o=1 for one cycle, exc_tval_o=captured address, wb_valid_o=0, no memory request issued for decode faults. Next state IDLE.
- ex_ready_o is 1 only in IDLE.
- Minimum latency: accept at T, req+gnt at T+1, rvalid at T+2, wb_valid at T+3, next accept at T+4. A decode exception fires at T+1.
- Lane math: off = addr[log2(XLEN/8)-1:0]. mem_be_o = size mask << off (B=1, H=3, W=F, D=FF).
- Write data: mem_wdata_o is the low size bytes of ex_wdata_i replicated across all lanes.
- Load data: shift rdata right by off*8 and take size bytes. Sign-extend for B/H/W/D; zero-extend for BU/HU/WU. The rdata lanes that are not enabled are ignored.
- rvalid while in IDLE or REQ is ignored (protocol violation, no effect).
- wb_data_o/exc_tval_o/exc_cause_o hold their last values outside pulses.

Test Plan:
- XLEN=32, LW 0x100, rdata 0xDEADBEEF, gnt same cycle, rvalid next -> mem_be_o=F, wb_data_o=0xDEADBEEF at T+3, wb_we_o=1.
- LB 0x103, rdata 0x80xxxxxx -> mem_addr_o=0x100, be=8, wb_data_o=0xFFFFFF80; same with LBU -> 0x00000080.
- SH 0x202, wdata 0x1234ABCD, gnt delayed 3 cycles -> mem_be_o=C, mem_wdata_o=0xABCDABCD held stable, wb_valid_o=1, wb_we_o=0.
- LW 0x102 -> exc_valid_o at T+1, cause 4, tval 0x102, mem_req_o never asserted; funct3 011 at XLEN=32 -> cause 2.
- Load with rvalid+mem_err_i -> cause 5. TIMEOUT=4 store, no rvalid -> cause 7 after 4 WAIT cycles. rst_n low in WAIT -> ex_ready_o=1, no pulses.
- XLEN=64, LWU 0x1004, rdata[63:32]=0x80000001 -> be=F0, wb_data_o=0x0000000080000001; SD 0x1008 -> be=FF.
